serial_add_ctrl: RTL and testbench

Bit-serial adder controller: accepts one WIDTH-bit add request, then sequences a single 1-bit full-adder cell (two half-adder stages plus carry OR) across all operand bits, one bit per clock. It trades latency for area: WIDTH cycles per operation, with a start/busy/done handshake. It sits between a requester (sequencer or testbench driver) and the shared 1-bit adder datapath, and is the building block for multi-cycle arithmetic in the combo-to-sequential progression of the design.

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 tb/tb_serial_add_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one WIDTH-bit add per WIDTH+2 cycles through a single 1-bit full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] opa, opb, res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;

   // Single full-adder cell built from two half adders plus the carry OR.
   logic ha1_s, ha1_c, ha2_c, bit_s, bit_c;

   always_comb begin
      ha1_s = opa[0] ^ opb[0];
      ha1_c = opa[0] & opb[0];
      bit_s = ha1_s ^ carry;
      ha2_c = ha1_s & carry;
      bit_c = ha1_c | ha2_c;
   end

   assign last = (cnt == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the working shift registers are reset too, so an aborted operation leaves no residue.
   always_ff @(posedge clk) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (state == IDLE && start) begin
         opa   <= a;
         opb   <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         opa   <= opa >> 1;
         opb   <= opb >> 1;
         res   <= {bit_s, res[WIDTH-1:1]};
         carry <= bit_c;
         if (!last) cnt <= cnt + 1'b1;
      end
   end

   // Results are published on the final RUN edge so they are visible with the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (state == RUN && last) begin
         sum  <= {bit_s, res[WIDTH-1:1]};
         cout <= bit_c;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // On the last bit, carry holds the carry into the MSB.
   always_ff @(posedge clk) begin
      if (rst)                     ovf <= 1'b0;
      else if (state == RUN && last) ovf <= carry ^ bit_c;
   end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a cycle-level reference model predicts results and handshake timing.
// Build with SERIAL_ADD_OVF_EN defined to also check the overflow output.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [W-1:0] a, b;
   logic         busy, done, cout;
   logic [W-1:0] sum;
   logic         ovf_obs;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
   assign ovf_obs = ovf;
`else
   assign ovf_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
      .cout  (cout),
      .ovf   (ovf)
`else
      .cout  (cout)
`endif
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   res_t         sb_q[$];
   res_t         pend;
   int           checks = 0;
   int           errors = 0;
   int           phase  = 0;   // 0 idle, 1..W run cycles, W+1 done cycle
   logic [W-1:0] exp_sum  = '0;
   logic         exp_cout = 1'b0;
   logic         exp_ovf  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic res_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      res_t         r;
      logic [W:0]   t;
      t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
      return r;
   endfunction

   // Apply one cycle of inputs and advance the reference model at the sampling edge.
   task automatic step(input logic r, input logic s, input logic [W-1:0] ai,
                       input logic [W-1:0] bi, input logic ci);
      rst = r; start = s; a = ai; b = bi; cin = ci;
      @(posedge clk);
      if (r) begin
         phase = 0;
         sb_q.delete();
         exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      end else if (phase == 0) begin
         if (s) begin
            pend = ref_add(ai, bi, ci);
            sb_q.push_back(pend);
            phase = 1;
         end
      end else if (phase == W) begin
         phase    = W + 1;
         exp_sum  = pend.sum;
         exp_cout = pend.cout;
         exp_ovf  = pend.ovf;
      end else if (phase == W + 1) begin
         phase = 0;
      end else begin
         phase++;
      end
      #1;
   endtask

   task automatic idle_cycle();
      step(1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
   endtask

   task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
      step(1'b0, 1'b1, ai, bi, ci);
      repeat (W + 1) step(1'b0, 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
   endtask

   // Monitor: compares handshake every cycle and pops the scoreboard on each done pulse.
   always begin
      res_t r;
      @(posedge clk);
      #2;
      check("busy", busy, (phase >= 1 && phase <= W));
      check("done", done, (phase == W + 1));
      check("busy_done_excl", busy & done, 1'b0);
      if (done === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: done pulse with no outstanding request (t=%0t)", $time);
         end else begin
            r = sb_q.pop_front();
            check("sb_sum", sum, r.sum);
            check("sb_cout", cout, r.cout);
`ifdef SERIAL_ADD_OVF_EN
            check("sb_ovf", ovf_obs, r.ovf);
`endif
         end
      end
      check("sum_held", sum, exp_sum);
      check("cout_held", cout, exp_cout);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf_held", ovf_obs, exp_ovf);
`endif
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b1; a = '0; b = '0; cin = 1'b0;

      // Reset held with start high: nothing may start.
      step(1'b1, 1'b1, 8'h35, 8'h4A, 1'b0);
      step(1'b1, 1'b1, 8'h35, 8'h4A, 1'b0);
      repeat (2) idle_cycle();

      // Directed vectors from the operating description.
      do_op(8'h35, 8'h4A, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0);
      do_op(8'h00, 8'h00, 1'b1);
      do_op(8'h7F, 8'h01, 1'b0);
      do_op(8'h80, 8'h80, 1'b0);
      idle_cycle();

      // Abort on the 4th RUN cycle, then a clean operation.
      step(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
      repeat (3) step(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
      step(1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
      repeat (2) idle_cycle();
      do_op(8'h12, 8'h34, 1'b0);

      // Start held high with operands changing every cycle.
      repeat (6 * (W + 2)) step(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      repeat (W + 2) idle_cycle();

      // Random operations with random gaps.
      for (int i = 0; i < 30; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 3)) idle_cycle();
      end

      // Fully random traffic including sporadic resets in any state.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
              W'($urandom), W'($urandom), 1'($urandom));

      repeat (W + 2) idle_cycle();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d results outstanding, expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
